rom_port_arbiter: RTL and testbench

- Shares one byte-wide synchronous-read program ROM port between two requesters: port 0 for instruction fetch and port 1 for data load.
- Each request is a byte read or a 16-bit little-endian word read. Word reads are sequenced as two pipelined byte reads, so a single ROM instance serves 16-bit fetch without the current duplicated even/odd instances.
- The block sits between the CPU fetch/load units and the ROM's (addr, enable_out, dataOut) port.

---
 rtl/rom_arb_pkg.sv | 15 +
 rtl/rom_rr_arbiter2.sv | 60 ++++++
 rtl/rom_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM port arbiter slice.
package rom_arb_pkg;

    // Default ROM byte-address width.
    localparam int ROM_ADDR_WIDTH = 7;

    // Sequencer states: accept, present address, capture low byte, capture high byte.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        CAP_LO = 2'd2,
        CAP_HI = 2'd3
    } rom_arb_state_e;

endpackage

// File: rtl/rom_rr_arbiter2.sv
// Two-input grant for the ROM port arbiter.
// Build option: ROM_ARB_FIXED_PRIO_EN -- when defined, port 0 always wins a tie
// and no last-grant state is kept; otherwise ties alternate round-robin.
module rom_rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic gnt0,
    output logic gnt1,
    output logic gnt_idx
);

`ifdef ROM_ARB_FIXED_PRIO_EN
    logic unused_rr;
    assign unused_rr = ^{clk, reset, accept};

    // Fixed priority: port 0 wins whenever it is asking.
    always_comb begin
        gnt0    = req0;
        gnt1    = req1 & ~req0;
        gnt_idx = req1 & ~req0;
    end
`else
    logic last_grant_q;
    logic last_grant_d;

    // Round-robin: on a tie, the port that did not win last time is granted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if (last_grant_q) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
        gnt_idx      = gnt1;
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = gnt1;
        end
    end

    // Remember the last winner; reset value 1 lets port 0 take the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one byte-wide synchronous-read ROM port between a fetch port (0) and
// a load port (1). Word reads are split into two pipelined byte reads.
// Build option: ROM_ARB_FIXED_PRIO_EN (see rom_rr_arbiter2) selects fixed priority.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ROM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic                  req0_word,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [15:0]           rsp0_data,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic                  req1_word,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [15:0]           rsp1_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_enable_out,
    input  logic [7:0]            rom_data
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    rom_arb_state_e        state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  word_q, word_d;
    logic                  owner_q, owner_d;
    logic [7:0]            lo_q, lo_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                  rom_en_q, rom_en_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic [15:0]           rsp0_data_q, rsp0_data_d;
    logic [15:0]           rsp1_data_q, rsp1_data_d;

    logic in_idle;
    logic accept;
    logic gnt0, gnt1, gnt_idx;

    assign in_idle = (state_q == IDLE);
    assign accept  = in_idle & (req0_valid | req1_valid);

    rom_rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0_valid),
        .req1    (req1_valid),
        .accept  (accept),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .gnt_idx (gnt_idx)
    );

    assign req0_ready     = in_idle & gnt0;
    assign req1_ready     = in_idle & gnt1;
    assign rom_addr       = rom_addr_q;
    assign rom_enable_out = rom_en_q;
    assign rsp0_valid     = rsp0_valid_q;
    assign rsp1_valid     = rsp1_valid_q;
    assign rsp0_data      = rsp0_data_q;
    assign rsp1_data      = rsp1_data_q;

    // Next-state and next-output logic; ROM address/enable are set one state
    // ahead so the registered values line up with the state they belong to.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        word_d       = word_q;
        owner_d      = owner_q;
        lo_d         = lo_q;
        rom_addr_d   = '0;
        rom_en_d     = 1'b0;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d     = gnt_idx ? req1_addr : req0_addr;
                    word_d     = gnt_idx ? req1_word : req0_word;
                    owner_d    = gnt_idx;
                    rom_addr_d = gnt_idx ? req1_addr : req0_addr;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                rom_en_d   = 1'b1;
                rom_addr_d = word_q ? (addr_q + ADDR_ONE) : addr_q;
                state_d    = CAP_LO;
            end
            CAP_LO: begin
                if (word_q) begin
                    lo_d       = rom_data;
                    rom_en_d   = 1'b1;
                    rom_addr_d = addr_q + ADDR_ONE;
                    state_d    = CAP_HI;
                end else begin
                    state_d = IDLE;
                    if (owner_q) begin
                        rsp1_valid_d = 1'b1;
                        rsp1_data_d  = {8'h00, rom_data};
                    end else begin
                        rsp0_valid_d = 1'b1;
                        rsp0_data_d  = {8'h00, rom_data};
                    end
                end
            end
            CAP_HI: begin
                state_d = IDLE;
                if (owner_q) begin
                    rsp1_valid_d = 1'b1;
                    rsp1_data_d  = {rom_data, lo_q};
                end else begin
                    rsp0_valid_d = 1'b1;
                    rsp0_data_d  = {rom_data, lo_q};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset discards any in-flight read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            word_q       <= 1'b0;
            owner_q      <= 1'b0;
            lo_q         <= 8'h00;
            rom_addr_q   <= '0;
            rom_en_q     <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= 16'h0000;
            rsp1_data_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            word_q       <= word_d;
            owner_q      <= owner_d;
            lo_q         <= lo_d;
            rom_addr_q   <= rom_addr_d;
            rom_en_q     <= rom_en_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a small synchronous-read ROM model.
// Honours ROM_ARB_FIXED_PRIO_EN when the design is built with it.
module tb_rom_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_word, req0_ready, rsp0_valid;
    logic [6:0]  req0_addr;
    logic [15:0] rsp0_data;
    logic        req1_valid, req1_word, req1_ready, rsp1_valid;
    logic [6:0]  req1_addr;
    logic [15:0] rsp1_data;
    logic [6:0]  rom_addr;
    logic        rom_enable_out;
    logic [7:0]  rom_data;

    logic [7:0]  mem [128];
    logic [7:0]  rom_q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rom_port_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .req0_valid     (req0_valid),
        .req0_addr      (req0_addr),
        .req0_word      (req0_word),
        .req0_ready     (req0_ready),
        .rsp0_valid     (rsp0_valid),
        .rsp0_data      (rsp0_data),
        .req1_valid     (req1_valid),
        .req1_addr      (req1_addr),
        .req1_word      (req1_word),
        .req1_ready     (req1_ready),
        .rsp1_valid     (rsp1_valid),
        .rsp1_data      (rsp1_data),
        .rom_addr       (rom_addr),
        .rom_enable_out (rom_enable_out),
        .rom_data       (rom_data)
    );

    // ROM model: address registered on the clock edge, data gated by enable.
    always @(posedge clk) rom_q <= mem[rom_addr];
    assign rom_data = rom_enable_out ? rom_q : 8'h00;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request on port p, starting at a negedge; returns at the response negedge.
    task automatic txn(input int p, input logic [6:0] a, input logic w,
                       input logic [15:0] exp, input string tag);
        int         n;
        logic       other_seen;
        logic [6:0] a1;
        a1 = a + 7'd1;
        if (p == 0) begin
            req0_valid = 1'b1; req0_addr = a; req0_word = w;
        end else begin
            req1_valid = 1'b1; req1_addr = a; req1_word = w;
        end
        #1;
        chk({tag, "_ready"}, (p == 0) ? req0_ready : req1_ready, 16'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 1;
        other_seen = 1'b0;
        while (!((p == 0) ? rsp0_valid : rsp1_valid) && n < 10) begin
            if (n == 1) begin
                chk({tag, "_addr_issue"}, rom_addr, a);
                chk({tag, "_en_issue"}, rom_enable_out, 16'd0);
            end
            if (n == 2) begin
                chk({tag, "_en_cap"}, rom_enable_out, 16'd1);
                if (w) chk({tag, "_addr_hi"}, rom_addr, a1);
            end
            if ((p == 0) ? rsp1_valid : rsp0_valid) other_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, w ? 16'd4 : 16'd3);
        chk({tag, "_data"}, (p == 0) ? rsp0_data : rsp1_data, exp);
        chk({tag, "_other_rsp"}, other_seen | ((p == 0) ? rsp1_valid : rsp0_valid), 16'd0);
    endtask

    function automatic logic [15:0] exp_grant(input int k);
`ifdef ROM_ARB_FIXED_PRIO_EN
        exp_grant = 16'd0;
`else
        exp_grant = 16'(k % 2);
`endif
    endfunction

    initial begin
        int   ng, nr, acc_c;
        logic seen;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[7'h00] = 8'h5A;
        mem[7'h04] = 8'h14;
        mem[7'h0A] = 8'hAC;
        mem[7'h0B] = 8'h3B;
        mem[7'h20] = 8'h11;
        mem[7'h21] = 8'h22;
        mem[7'h30] = 8'h99;
        mem[7'h7F] = 8'hE5;

        req0_valid = 1'b0; req0_addr = '0; req0_word = 1'b0;
        req1_valid = 1'b0; req1_addr = '0; req1_word = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_ready0", req0_ready, 16'd0);
        chk("rst_rsp0_valid", rsp0_valid, 16'd0);
        chk("rst_rsp1_valid", rsp1_valid, 16'd0);
        chk("rst_rom_en", rom_enable_out, 16'd0);
        chk("rst_rom_addr", rom_addr, 16'd0);
        chk("rst_rsp0_data", rsp0_data, 16'd0);
        reset = 1'b0;
        @(negedge clk);

        // Byte read then back-to-back byte read on port 0
        txn(0, 7'h04, 1'b0, 16'h0014, "byte0");
        chk("b2b_rsp_coincide", rsp0_valid, 16'd1);
        txn(0, 7'h30, 1'b0, 16'h0099, "b2b");
        @(negedge clk);
        chk("rsp0_pulse_drop", rsp0_valid, 16'd0);
        chk("rsp0_data_hold", rsp0_data, 16'h0099);

        // Word reads on port 1, including address wrap
        txn(1, 7'h0A, 1'b1, 16'h3BAC, "word1");
        txn(1, 7'h7F, 1'b1, 16'h5AE5, "wrap");
        @(negedge clk);

        // Reset during CAP_LO
        req1_valid = 1'b1; req1_addr = 7'h20; req1_word = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        chk("mid_en_before", rom_enable_out, 16'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_en_async", rom_enable_out, 16'd0);
        chk("mid_addr_async", rom_addr, 16'd0);
        chk("mid_rsp1_data", rsp1_data, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp1_valid) seen = 1'b1;
        end
        chk("mid_no_rsp", seen, 16'd0);
        txn(1, 7'h20, 1'b1, 16'h2211, "post_rst");
        @(negedge clk);

        // Both ports continuously requesting words
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req0_valid = 1'b1; req0_addr = 7'h0A; req0_word = 1'b1;
        req1_valid = 1'b1; req1_addr = 7'h7F; req1_word = 1'b1;
        ng = 0; nr = 0; acc_c = 0;
        for (int c = 0; c < 40 && nr < 4; c++) begin
            #1;
            if (rsp0_valid || rsp1_valid) begin
                nr++;
                if (rsp0_valid) chk("alt_rsp0_data", rsp0_data, 16'h3BAC);
                else            chk("alt_rsp1_data", rsp1_data, 16'h5AE5);
                chk("alt_latency", 16'(c - acc_c), 16'd4);
                if (nr == 4) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
            if (nr < 4 && (req0_ready || req1_ready)) begin
                if (ng < 4) chk("alt_grant", {15'd0, req1_ready}, exp_grant(ng));
                ng++;
                acc_c = c;
            end
            @(negedge clk);
        end
        chk("alt_rsp_count", 16'(nr), 16'd4);
        chk("alt_grant_count", 16'(ng), 16'd4);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
